// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch predictor / resolver slice.
//   - BR_* : encodings of the 3-bit branch_src selector
//   - bht_state_t : 2-bit saturating predictor counter states
//   - is_conditional() : true for branch types that train the predictor
//   - bht_next() : saturating counter step toward the resolved outcome
// ---------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_NONE = 3'b010;
    localparam logic [2:0] BR_JUMP = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;
    localparam logic [2:0] BR_BLTU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    // Only real conditional branches train the table; "no branch" and
    // unconditional jumps carry no useful direction history.
    function automatic logic is_conditional(input logic [2:0] src);
        return !((src == BR_NONE) || (src == BR_JUMP));
    endfunction

    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluation.
// Ports:
//   data_1, data_2 : rs1 / rs2 operands (DATA_WIDTH)
//   branch_src     : branch type selector (BR_* encoding)
//   valid          : instruction in execute is a branch/jump
//   taken          : resolved outcome, forced low when valid is low
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [2:0]            branch_src,
    input  logic                  valid,
    output logic                  taken
);

    logic eq;
    logic lt_s;
    logic lt_u;
    logic cond;

    assign eq   = (data_1 == data_2);
    assign lt_s = ($signed(data_1) < $signed(data_2));
    assign lt_u = (data_1 < data_2);

    always_comb begin
        // NOTE: default assigned before the case so every path drives cond;
        // otherwise a latch is inferred.
        cond = 1'b0;
        case (branch_src)
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_NONE: cond = 1'b0;
            BR_JUMP: cond = 1'b1;
            BR_BLT:  cond = lt_s;
            BR_BGE:  cond = !lt_s;
            BR_BGEU: cond = !lt_u;
            BR_BLTU: cond = lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign taken = valid && cond;

endmodule

// File: rtl/branch_predict_resolve.sv
// ---------------------------------------------------------------------------
// branch_predict_resolve
// Fetch-stage 2-bit BHT predictor plus execute-stage branch resolution.
// Ports:
//   clk, rst           : clock (rising edge), async active-high reset
//   fetch_pc           : PC being fetched
//   fetch_pred_taken   : prediction for fetch_pc (MSB of indexed counter)
//   ex_valid           : branch/jump present in execute
//   ex_pc              : PC of the execute instruction (selects entry to train)
//   ex_branch_src      : branch type selector
//   ex_data_1/2        : rs1 / rs2 operands
//   ex_pred_taken      : prediction made at fetch for this instruction
//   pc_src             : resolved outcome (select branch target)
//   mispredict, flush  : outcome disagrees with prediction
//   branch_count       : saturating count of conditional branches resolved
//   mispredict_count   : saturating count of mispredictions of any type
// ---------------------------------------------------------------------------
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_LSB   = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  fetch_pc,
    output logic                   fetch_pred_taken,
    input  logic                   ex_valid,
    input  logic [DATA_WIDTH-1:0]  ex_pc,
    input  logic [2:0]             ex_branch_src,
    input  logic [DATA_WIDTH-1:0]  ex_data_1,
    input  logic [DATA_WIDTH-1:0]  ex_data_2,
    input  logic                   ex_pred_taken,
    output logic                   pc_src,
    output logic                   mispredict,
    output logic                   flush,
    output logic [COUNT_WIDTH-1:0] branch_count,
    output logic [COUNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    bht_state_t bht_q [BHT_ENTRIES];
    bht_state_t bht_entry_d;

    logic [COUNT_WIDTH-1:0] branch_count_q,     branch_count_d;
    logic [COUNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             bht_update;
    logic             unused_pc_bits;

    assign fetch_idx = fetch_pc[INDEX_LSB +: IDX_W];
    assign ex_idx    = ex_pc[INDEX_LSB +: IDX_W];

    // Only the index slice of each PC is meaningful here.
    assign unused_pc_bits = ^{fetch_pc, ex_pc};

    // Read from registered state only: a same-cycle update to this entry
    // becomes visible on the following cycle.
    assign fetch_pred_taken = bht_q[fetch_idx][1];

    branch_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond_eval (
        .data_1     (ex_data_1),
        .data_2     (ex_data_2),
        .branch_src (ex_branch_src),
        .valid      (ex_valid),
        .taken      (pc_src)
    );

    assign mispredict = ex_valid && (pc_src != ex_pred_taken);
    assign flush      = mispredict;

    assign bht_update = ex_valid && is_conditional(ex_branch_src);

    always_comb begin
        bht_entry_d        = bht_next(bht_q[ex_idx], pc_src);
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        // Counters saturate at all-ones instead of wrapping.
        if (bht_update && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + CNT_ONE;
        end
        if (mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table is reset explicitly because its WNT start value
            // is observable through fetch_pred_taken; it cannot be left to RAM
            // power-up contents.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= WNT;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so read/write ordering cannot race.
            if (bht_update) begin
                bht_q[ex_idx] <= bht_entry_d;
            end
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_resolve
// Self-checking bench: table of resolution vectors plus hand-written
// sequences (counter walk, jump, same-index read/write, async reset).
// Uses COUNT_WIDTH = 4 so counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_branch_predict_resolve;

    localparam int DW = 32;
    localparam int NE = 64;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] fetch_pc;
    logic          fetch_pred_taken;
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [2:0]    ex_branch_src;
    logic [DW-1:0] ex_data_1;
    logic [DW-1:0] ex_data_2;
    logic          ex_pred_taken;
    logic          pc_src;
    logic          mispredict;
    logic          flush;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_predict_resolve #(
        .DATA_WIDTH  (DW),
        .BHT_ENTRIES (NE),
        .INDEX_LSB   (2),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_branch_src    (ex_branch_src),
        .ex_data_1        (ex_data_1),
        .ex_data_2        (ex_data_2),
        .ex_pred_taken    (ex_pred_taken),
        .pc_src           (pc_src),
        .mispredict       (mispredict),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept by the bench
    int bht_m [NE];
    int bc_m;
    int mc_m;

    typedef struct {
        logic pc_src;
        logic mis;
        logic pred;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        valid;
        logic [2:0]  src;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        pred;
        logic        exp_pc_src;
        logic        exp_mis;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(NE - 1));
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        return bht_m[idx_of(pc)] >= 2;
    endfunction

    function automatic logic is_cond(input logic [2:0] s);
        return (s != 3'b010) && (s != 3'b011);
    endfunction

    function automatic int sat_cnt(input int c);
        return (c >= 15) ? 15 : c + 1;
    endfunction

    function automatic logic ref_taken(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        logic r;
        case (s)
            3'b000: r = (a == b);
            3'b001: r = (a != b);
            3'b010: r = 1'b0;
            3'b011: r = 1'b1;
            3'b100: r = ($signed(a) < $signed(b));
            3'b101: r = !($signed(a) < $signed(b));
            3'b110: r = !(a < b);
            default: r = (a < b);
        endcase
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NE; i++) bht_m[i] = 1;
        bc_m = 0;
        mc_m = 0;
    endtask

    // One execute cycle: drive at negedge, check combinational outputs 1
    // time unit later, then check registered effects just after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic [2:0] src, input logic [31:0] a, input logic [31:0] b,
                        input logic p, input logic e_pc, input logic e_mis);
        exp_t e;
        int   ix;
        @(negedge clk);
        ex_valid      = v;
        ex_pc         = pc;
        ex_branch_src = src;
        ex_data_1     = a;
        ex_data_2     = b;
        ex_pred_taken = p;
        fetch_pc      = pc;
        e.pc_src = e_pc;
        e.mis    = e_mis;
        e.pred   = model_pred(pc);
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " pc_src"},     32'(pc_src),           32'(e.pc_src));
            check({tag, " mispredict"}, 32'(mispredict),       32'(e.mis));
            check({tag, " flush"},      32'(flush),            32'(e.mis));
            check({tag, " pred_pre"},   32'(fetch_pred_taken), 32'(e.pred));
        end
        @(posedge clk);
        ix = idx_of(pc);
        if (v && is_cond(src)) begin
            if (e_pc) bht_m[ix] = (bht_m[ix] == 3) ? 3 : bht_m[ix] + 1;
            else      bht_m[ix] = (bht_m[ix] == 0) ? 0 : bht_m[ix] - 1;
            bc_m = sat_cnt(bc_m);
        end
        if (v && e_mis) mc_m = sat_cnt(mc_m);
        #1;
        check({tag, " branch_count"},     32'(branch_count),     32'(bc_m));
        check({tag, " mispredict_count"}, 32'(mispredict_count), 32'(mc_m));
        check({tag, " pred_post"},        32'(fetch_pred_taken), 32'(model_pred(pc)));
    endtask

    task automatic br(input string tag, input logic [31:0] pc, input logic [2:0] src,
                      input logic [31:0] a, input logic [31:0] b, input logic p);
        logic t;
        t = ref_taken(src, a, b);
        step(tag, 1'b1, pc, src, a, b, p, t, t != p);
    endtask

    localparam logic [31:0] WALK_PC = 32'h0000_30F0;  // index 60
    localparam logic [31:0] BYP_PC  = 32'h0000_2040;  // index 16

    initial begin
        //             valid src     d1            d2            pred pc_src mis
        vecs[0]  = '{1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 3'b001, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'b101, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'b111, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'b010, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'b011, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 3'b011, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 3'b010, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 3'b110, 32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, 1'b0};

        reset_model();
        rst           = 1'b1;
        fetch_pc      = 32'h0000_0100;
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_branch_src = 3'b010;
        ex_data_1     = '0;
        ex_data_2     = '0;
        ex_pred_taken = 1'b0;

        // Reset state is visible before any clock edge
        #3;
        check("reset pred",             32'(fetch_pred_taken), 32'd0);
        check("reset branch_count",     32'(branch_count),     32'd0);
        check("reset mispredict_count", 32'(mispredict_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset pred",         32'(fetch_pred_taken), 32'd0);
        check("post-reset branch_count", 32'(branch_count),     32'd0);

        // Table-driven resolution vectors, each on its own BHT entry
        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), vecs[i].valid, 32'h0000_2000 + 32'(i * 4),
                 vecs[i].src, vecs[i].d1, vecs[i].d2, vecs[i].pred,
                 vecs[i].exp_pc_src, vecs[i].exp_mis);
        end

        // Jump predicted not-taken: mispredict, no training, no branch count
        br("jump", WALK_PC, 3'b011, 32'h0, 32'h0, 1'b0);

        // Same-index fetch and update: WNT entry, taken outcome
        br("bypass", BYP_PC, 3'b000, 32'h1, 32'h1, 1'b0);

        // Counter walk on one entry: up to ST and hold, down to SNT and hold,
        // then taken twice (SNT->WNT still predicts 0, WNT->WT predicts 1).
        for (int k = 0; k < 3; k++)
            br($sformatf("walk_up%0d", k), WALK_PC, 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b0);
        for (int k = 0; k < 4; k++)
            br($sformatf("walk_dn%0d", k), WALK_PC, 3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1);
        for (int k = 0; k < 2; k++)
            br($sformatf("walk_re%0d", k), WALK_PC, 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b0);

        // Extra branches with counters already saturated at 4'hF
        br("sat0", WALK_PC, 3'b001, 32'h1, 32'h2, 1'b0);
        br("sat1", WALK_PC, 3'b001, 32'h1, 32'h2, 1'b0);

        // Asynchronous reset mid-cycle with an update pending at the edge
        @(negedge clk);
        ex_valid      = 1'b1;
        ex_pc         = WALK_PC;
        ex_branch_src = 3'b100;
        ex_data_1     = 32'hFFFF_FFFF;
        ex_data_2     = 32'h1;
        ex_pred_taken = 1'b0;
        fetch_pc      = 32'h0000_2000;
        #1;
        check("pre-rst pred idx0", 32'(fetch_pred_taken), 32'(model_pred(32'h0000_2000)));
        #1;
        rst = 1'b1;
        #1;
        reset_model();
        check("async rst branch_count",     32'(branch_count),     32'd0);
        check("async rst mispredict_count", 32'(mispredict_count), 32'd0);
        check("async rst pred idx0",        32'(fetch_pred_taken), 32'd0);
        check("async rst pc_src comb",      32'(pc_src),           32'd1);
        @(posedge clk);
        #1;
        fetch_pc = WALK_PC;
        #1;
        check("rst discards update", 32'(fetch_pred_taken), 32'd0);
        check("rst held counters",   32'(branch_count),     32'd0);
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes from the clean state
        br("after_rst", 32'h0000_2000, 3'b000, 32'h4, 32'h4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
